// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with signed branches, stall, and a hardware
// return-address stack reporting full/empty and a sticky overflow/underflow error.
module program_counter_stack #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           OFFSET_WIDTH = 9,
  parameter int unsigned           STACK_DEPTH  = 8,
  parameter int unsigned           INCREMENT    = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    Stall,
  input  logic                    LoadEnable,
  input  logic [ADDR_WIDTH-1:0]   LoadValue,
  input  logic                    OffsetEnable,
  input  logic [OFFSET_WIDTH-1:0] Offset,
  input  logic                    CallEnable,
  input  logic                    ReturnEnable,
  input  logic                    ErrorClear,
  output logic [ADDR_WIDTH-1:0]   CounterValue,
  output logic                    StackFull,
  output logic                    StackEmpty,
  output logic                    StackError
);

  localparam int unsigned           PTR_WIDTH  = $clog2(STACK_DEPTH);
  localparam logic [PTR_WIDTH:0]    COUNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]    COUNT_FULL = (PTR_WIDTH+1)'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] INC_STEP   = ADDR_WIDTH'(INCREMENT);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RETURN,
    OP_UNDERFLOW,
    OP_CALL,
    OP_OVERFLOW,
    OP_LOAD,
    OP_OFFSET,
    OP_INC
  } op_t;

  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [PTR_WIDTH:0]    count, count_next;
  logic                  error, error_next;
  logic                  push;
  op_t                   op;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] offset_ext;
  logic [PTR_WIDTH-1:0]  top_idx;
  logic                  full, empty;

  assign pc_inc     = pc + INC_STEP;
  assign offset_ext = ADDR_WIDTH'($signed(Offset));
  assign top_idx    = PTR_WIDTH'(count - COUNT_ONE);
  assign full       = (count == COUNT_FULL);
  assign empty      = (count == '0);

  // Priority decode: only the highest-ranked request acts this cycle.
  always_comb begin
    op = OP_INC;
    if (Stall)             op = OP_HOLD;
    else if (ReturnEnable) op = empty ? OP_UNDERFLOW : OP_RETURN;
    else if (CallEnable)   op = full ? OP_OVERFLOW : OP_CALL;
    else if (LoadEnable)   op = OP_LOAD;
    else if (OffsetEnable) op = OP_OFFSET;
  end

  always_comb begin
    pc_next    = pc;
    count_next = count;
    error_next = error;
    push       = 1'b0;
    // Clear first so a same-cycle overflow/underflow wins below.
    if (op != OP_HOLD && ErrorClear) error_next = 1'b0;
    unique case (op)
      OP_HOLD: ;
      OP_RETURN: begin
        pc_next    = stack_mem[top_idx];
        count_next = count - COUNT_ONE;
      end
      OP_UNDERFLOW: begin
        pc_next    = pc_inc;
        error_next = 1'b1;
      end
      OP_CALL: begin
        pc_next    = LoadValue;
        count_next = count + COUNT_ONE;
        push       = 1'b1;
      end
      OP_OVERFLOW: begin
        pc_next    = LoadValue;
        error_next = 1'b1;
      end
      OP_LOAD:   pc_next = LoadValue;
      OP_OFFSET: pc_next = pc + offset_ext;
      OP_INC:    pc_next = pc_inc;
      default:   pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc    <= RESET_VECTOR;
      count <= '0;
      error <= 1'b0;
    end else begin
      pc    <= pc_next;
      count <= count_next;
      error <= error_next;
    end
  end

  // Entry storage carries no reset; contents are meaningless while count is 0.
  always_ff @(posedge Clock) begin
    if (push) stack_mem[count[PTR_WIDTH-1:0]] <= pc_inc;
  end

  assign CounterValue = pc;
  assign StackFull    = full;
  assign StackEmpty   = empty;
  assign StackError   = error;

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the processor fetch stage.
- Adds the following over the basic PC:
  - configurable address width and reset vector;
  - signed relative branches;
  - a configurable step;
  - a pipeline stall input;
  - a hardware return-address stack for call/return, with full/empty status and sticky error reporting.
- Drives the instruction-memory address every cycle.

Parameters:
- ADDR_WIDTH, 16, width of PC, LoadValue and stack entries.
- OFFSET_WIDTH, 9, width of the two's-complement branch offset.
- STACK_DEPTH, 8, number of return-address entries; power of two, minimum 2.
- INCREMENT, 1, sequential step added when no other operation is active.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous active-low reset.
- Stall  in  1  hold PC, stack and flags unchanged this cycle.
- LoadEnable  in  1  absolute jump: PC <= LoadValue.
- LoadValue  in  ADDR_WIDTH  jump/call target.
- OffsetEnable  in  1  relative branch: PC <= PC + sext(Offset).
- Offset  in  OFFSET_WIDTH  signed branch offset.
- CallEnable  in  1  push PC+INCREMENT, then PC <= LoadValue.
- ReturnEnable  in  1  pop top of stack into PC.
- ErrorClear  in  1  clears StackError.
- CounterValue  out  ADDR_WIDTH  current PC.
- StackFull  out  1  stack holds STACK_DEPTH entries.
- StackEmpty  out  1  stack holds 0 entries.
- StackError  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset:
  - nReset low asynchronously forces CounterValue=RESET_VECTOR, stack count=0, StackEmpty=1, StackFull=0, StackError=0.
  - Stack entry contents are don't-care after reset.
- Registered outputs: all updates take effect on the rising Clock edge. CounterValue, StackFull and StackEmpty reflect the new state one cycle after the request.
- Priority per cycle, highest first: Stall > ReturnEnable > CallEnable > LoadEnable > OffsetEnable > increment. Only the highest active operation executes; lower requests that cycle are ignored.
- Stall=1: PC, stack, count and StackError are all held. ErrorClear is also ignored while stalled.
- Increment: PC <= PC + INCREMENT.
- Load: PC <= LoadValue.
- Offset:
  - Offset is sign-extended to ADDR_WIDTH and added to the current PC (not PC+INCREMENT).
  - Example: Offset=9'h1FF means -1.
- Arithmetic wraps modulo 2^ADDR_WIDTH; there is no overflow indication for PC arithmetic.
- Call, stack not full: push (PC+INCREMENT) mod 2^ADDR_WIDTH, count+1, PC <= LoadValue.
- Call, stack full (overflow):
  - PC <= LoadValue still occurs.
  - Push is discarded; stack contents and count are unchanged.
  - StackError <= 1.
- Return, stack not empty: PC <= top entry, count-1.
- Return, stack empty (underflow): PC <= PC + INCREMENT, count stays 0, StackError <= 1.
- Stack is LIFO: a return always pops the most recent unpopped push.
- StackFull = (count==STACK_DEPTH). StackEmpty = (count==0). The count register is clog2(STACK_DEPTH)+1 bits.
- StackError:
  - Set by overflow or underflow.
  - Cleared by ErrorClear=1 when not stalled.
  - If a set event and ErrorClear occur in the same cycle, the set wins.
- Reset mid-operation (nReset asserted between edges): outputs change immediately to reset values. Any pending operation is lost.
- Release of nReset is synchronised externally; the block needs no internal reset synchroniser.

Test Plan:
- Reset, sequential and wrap:
  - RESET_VECTOR=16'h0100 with nReset pulsed mid-cycle → CounterValue=16'h0100 immediately.
  - 3 idle cycles → 16'h0103.
  - Load 16'hFFFF then idle → 16'h0000 (wrap).
- Signed branch:
  - PC=16'h0040, Offset=9'h1F0 (-16) → 16'h0030.
  - Offset=9'h0FF (+255) from 16'h0030 → 16'h012F.
- Priority and stall:
  - PC=16'h0010, LoadEnable=1, LoadValue=16'h0200, OffsetEnable=1 → 16'h0200.
  - Repeat with Stall=1 → PC holds 16'h0010.
- Nested call/return:
  - Call to 16'h0300 from 16'h0010, then call to 16'h0400 from 16'h0300.
  - Return → 16'h0301; return → 16'h0011.
  - StackEmpty=1, StackError=0.
- Overflow (STACK_DEPTH=8):
  - 9 consecutive calls → ninth jumps to LoadValue, StackFull=1, StackError=1.
  - 8 returns yield the 8 pushed addresses in reverse order.
  - ErrorClear → StackError=0.
- Underflow:
  - Return on empty stack at PC=16'h0050 → PC=16'h0051, StackError=1.
  - ErrorClear in the same cycle as a second underflow → StackError stays 1.
